// File: rtl/rt_pkg.sv
// Shared definitions for the ray-triangle issue engine.
//   - FSM state encoding for rt_tri_issue
//   - word positions inside the packed ray and triangle buses
//   - default word/index/count widths
package rt_pkg;

   localparam int unsigned W_DEF    = 32;
   localparam int unsigned IDXW_DEF = 16;
   localparam int unsigned CNTW_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rt_state_e;

   // Word positions within the packed buses, counted from the LSB word.
   // The first-listed component sits in the MSBs.
   localparam int unsigned RAY_WORDS = 6;
   localparam int unsigned RAY_OX    = 5;
   localparam int unsigned RAY_OY    = 4;
   localparam int unsigned RAY_OZ    = 3;
   localparam int unsigned RAY_DX    = 2;
   localparam int unsigned RAY_DY    = 1;
   localparam int unsigned RAY_DZ    = 0;

   localparam int unsigned TRI_WORDS = 9;
   localparam int unsigned TRI_V0X   = 8;
   localparam int unsigned TRI_V0Y   = 7;
   localparam int unsigned TRI_V0Z   = 6;
   localparam int unsigned TRI_V1X   = 5;
   localparam int unsigned TRI_V1Y   = 4;
   localparam int unsigned TRI_V1Z   = 3;
   localparam int unsigned TRI_V2X   = 2;
   localparam int unsigned TRI_V2Y   = 1;
   localparam int unsigned TRI_V2Z   = 0;

   // LSB bit position of a word field, for use as bus[field_lsb(k, w) +: w].
   function automatic int unsigned field_lsb(input int unsigned word, input int unsigned w);
      return word * w;
   endfunction

endpackage

// File: rtl/rt_hit_keep.sv
// Closest-hit register. Holds the best (smallest t) hit seen since the last
// clear together with its u/v and triangle index.
// Ports:
//   clk, rstn          clock, async active-low reset
//   clr_i              forget the current best (new request accepted)
//   upd_i              a hit return is presented this cycle
//   t_i, u_i, v_i      hit values of the presented return
//   idx_i              triangle index of the presented return
//   best_valid_o       at least one hit kept since the last clear
//   best_t/u/v/idx_o   kept closest hit
module rt_hit_keep
   import rt_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned IDXW = IDXW_DEF
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            clr_i,
   input  logic            upd_i,
   input  logic [W-1:0]    t_i,
   input  logic [W-1:0]    u_i,
   input  logic [W-1:0]    v_i,
   input  logic [IDXW-1:0] idx_i,
   output logic            best_valid_o,
   output logic [W-1:0]    best_t_o,
   output logic [W-1:0]    best_u_o,
   output logic [W-1:0]    best_v_o,
   output logic [IDXW-1:0] best_idx_o
);

   logic            best_valid_q, best_valid_d;
   logic [W-1:0]    best_t_q, best_t_d;
   logic [W-1:0]    best_u_q, best_u_d;
   logic [W-1:0]    best_v_q, best_v_d;
   logic [IDXW-1:0] best_idx_q, best_idx_d;
   logic            take_new;

   // Strict less-than: on equal t the earlier-returned (lower index) hit stays.
   assign take_new = upd_i && (!best_valid_q || (t_i < best_t_q));

   always_comb begin
      best_valid_d = best_valid_q;
      best_t_d     = best_t_q;
      best_u_d     = best_u_q;
      best_v_d     = best_v_q;
      best_idx_d   = best_idx_q;
      if (clr_i) begin
         best_valid_d = 1'b0;
         best_t_d     = '0;
         best_u_d     = '0;
         best_v_d     = '0;
         best_idx_d   = '0;
      end else if (take_new) begin
         best_valid_d = 1'b1;
         best_t_d     = t_i;
         best_u_d     = u_i;
         best_v_d     = v_i;
         best_idx_d   = idx_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         best_valid_q <= 1'b0;
         best_t_q     <= '0;
         best_u_q     <= '0;
         best_v_q     <= '0;
         best_idx_q   <= '0;
      end else begin
         best_valid_q <= best_valid_d;
         best_t_q     <= best_t_d;
         best_u_q     <= best_u_d;
         best_v_q     <= best_v_d;
         best_idx_q   <= best_idx_d;
      end
   end

   assign best_valid_o = best_valid_q;
   assign best_t_o     = best_t_q;
   assign best_u_o     = best_u_q;
   assign best_v_o     = best_v_q;
   assign best_idx_o   = best_idx_q;

endmodule

// File: rtl/rt_tri_issue.sv
// Leaf-triangle issue and closest-hit collection engine.
// Accepts one ray plus a contiguous triangle range, reads each triangle from
// triangle memory, streams ray/triangle pairs one per cycle to the
// intersection unit, collects the in-order returns and reports the closest
// hit on a valid/ready result port.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   req_*                          request handshake (ray, base, count, cull)
//   mem_rd_en/addr, mem_rd_data    triangle memory, 1-cycle read latency
//   isect_*                        initiator side of the intersection unit
//   ret_*                          in-order returns from the intersection unit
//   res_*                          closest-hit result handshake
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; req_ready high
// FETCH    | one triangle read per cycle, base+0 .. base+count-1
// DRAIN    | all reads issued, waiting for the outstanding returns
// DONE     | result presented until res_ready
module rt_tri_issue
   import rt_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned IDXW = IDXW_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [RAY_WORDS*W-1:0] req_ray,
   input  logic [IDXW-1:0]        req_base,
   input  logic [CNTW-1:0]        req_count,
   input  logic                   req_cull,
   output logic                   mem_rd_en,
   output logic [IDXW-1:0]        mem_rd_addr,
   input  logic [TRI_WORDS*W-1:0] mem_rd_data,
   output logic                   isect_valid,
   output logic [RAY_WORDS*W-1:0] isect_ray,
   output logic [TRI_WORDS*W-1:0] isect_tri,
   output logic                   isect_cull,
   input  logic                   ret_valid,
   input  logic                   ret_hit,
   input  logic [W-1:0]           ret_t,
   input  logic [W-1:0]           ret_u,
   input  logic [W-1:0]           ret_v,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   res_hit,
   output logic [W-1:0]           res_t,
   output logic [W-1:0]           res_u,
   output logic [W-1:0]           res_v,
   output logic [IDXW-1:0]        res_idx
);

   rt_state_e              state_q, state_d;
   logic [RAY_WORDS*W-1:0] ray_q;
   logic                   cull_q;
   logic [IDXW-1:0]        base_q;
   logic [CNTW-1:0]        count_q;
   logic [CNTW-1:0]        issue_cnt_q, issue_cnt_d;
   logic [CNTW-1:0]        ret_cnt_q, ret_cnt_d;
   logic                   isect_valid_q;

   logic                   req_hs;
   logic                   ret_acc;
   logic                   last_issue;
   logic [CNTW-1:0]        ret_cnt_inc;
   logic [IDXW-1:0]        ret_idx;

   logic                   best_valid;
   logic [W-1:0]           best_t, best_u, best_v;
   logic [IDXW-1:0]        best_idx;

   assign req_hs      = req_valid && req_ready;
   // Returns outside an active request are protocol errors and are dropped.
   assign ret_acc     = ret_valid && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
   assign last_issue  = (issue_cnt_q == (count_q - CNTW'(1)));
   assign ret_cnt_inc = ret_cnt_q + CNTW'(1);
   assign ret_idx     = base_q + IDXW'(ret_cnt_q);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_hs) begin
               state_d = (req_count == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (last_issue) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Outstanding-count completion: independent of the unit latency.
            if ((ret_cnt_q == count_q) || (ret_acc && (ret_cnt_inc == count_q))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      req_ready = 1'b0;
      mem_rd_en = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         ST_IDLE:  req_ready = 1'b1;
         ST_FETCH: mem_rd_en = 1'b1;
         ST_DONE:  res_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- request capture ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ray_q   <= '0;
         cull_q  <= 1'b0;
         base_q  <= '0;
         count_q <= '0;
      end else if (req_hs) begin
         ray_q   <= req_ray;
         cull_q  <= req_cull;
         base_q  <= req_base;
         count_q <= req_count;
      end
   end

   // ---------------- issue / return counters ----------------
   always_comb begin
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      if (req_hs) begin
         issue_cnt_d = '0;
         ret_cnt_d   = '0;
      end else begin
         if (mem_rd_en) begin
            issue_cnt_d = issue_cnt_q + CNTW'(1);
         end
         if (ret_acc) begin
            ret_cnt_d = ret_cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         issue_cnt_q   <= '0;
         ret_cnt_q     <= '0;
         isect_valid_q <= 1'b0;
      end else begin
         issue_cnt_q   <= issue_cnt_d;
         ret_cnt_q     <= ret_cnt_d;
         // Read data arrives one cycle after the strobe, so the unit's
         // valid is simply the strobe delayed by one.
         isect_valid_q <= mem_rd_en;
      end
   end

   assign mem_rd_addr = base_q + IDXW'(issue_cnt_q);
   assign isect_valid = isect_valid_q;
   assign isect_ray   = ray_q;
   assign isect_tri   = mem_rd_data;
   assign isect_cull  = cull_q;

   // ---------------- closest-hit keeper ----------------
   rt_hit_keep #(
      .W    (W),
      .IDXW (IDXW)
   ) u_hit_keep (
      .clk          (clk),
      .rstn         (rstn),
      .clr_i        (req_hs),
      .upd_i        (ret_acc && ret_hit),
      .t_i          (ret_t),
      .u_i          (ret_u),
      .v_i          (ret_v),
      .idx_i        (ret_idx),
      .best_valid_o (best_valid),
      .best_t_o     (best_t),
      .best_u_o     (best_u),
      .best_v_o     (best_v),
      .best_idx_o   (best_idx)
   );

   // Result fields read as zero unless a hit is being presented.
   assign res_hit = res_valid && best_valid;
   assign res_t   = res_hit ? best_t   : '0;
   assign res_u   = res_hit ? best_u   : '0;
   assign res_v   = res_hit ? best_v   : '0;
   assign res_idx = res_hit ? best_idx : '0;

endmodule

// File: tb/tb_rt_tri_issue.sv
// Scoreboard bench for rt_tri_issue: directed requests push expected results
// and read addresses; negedge monitors pop and compare.
module tb_rt_tri_issue;
   import rt_pkg::*;

   localparam int W    = 32;
   localparam int IDXW = 16;
   localparam int CNTW = 8;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic [6*W-1:0]         req_ray = '0;
   logic [IDXW-1:0]        req_base = '0;
   logic [CNTW-1:0]        req_count = '0;
   logic                   req_cull = 1'b0;
   logic                   mem_rd_en;
   logic [IDXW-1:0]        mem_rd_addr;
   logic [9*W-1:0]         mem_rd_data = '0;
   logic                   isect_valid;
   logic [6*W-1:0]         isect_ray;
   logic [9*W-1:0]         isect_tri;
   logic                   isect_cull;
   logic                   ret_valid, ret_hit;
   logic [W-1:0]           ret_t, ret_u, ret_v;
   logic                   res_valid;
   logic                   res_ready = 1'b1;
   logic                   res_hit;
   logic [W-1:0]           res_t, res_u, res_v;
   logic [IDXW-1:0]        res_idx;

   always #5 clk = ~clk;

   rt_tri_issue #(.W(W), .IDXW(IDXW), .CNTW(CNTW)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_ray     (req_ray),
      .req_base    (req_base),
      .req_count   (req_count),
      .req_cull    (req_cull),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .isect_valid (isect_valid),
      .isect_ray   (isect_ray),
      .isect_tri   (isect_tri),
      .isect_cull  (isect_cull),
      .ret_valid   (ret_valid),
      .ret_hit     (ret_hit),
      .ret_t       (ret_t),
      .ret_u       (ret_u),
      .ret_v       (ret_v),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_hit     (res_hit),
      .res_t       (res_t),
      .res_u       (res_u),
      .res_v       (res_v),
      .res_idx     (res_idx)
   );

   typedef struct {
      logic            hit;
      logic [W-1:0]    t;
      logic [W-1:0]    u;
      logic [W-1:0]    v;
      logic [IDXW-1:0] idx;
      int              lat;
   } exp_t;

   exp_t            sb_q[$];
   logic [IDXW-1:0] addr_q[$];
   int              total = 0;
   int              bad = 0;
   int              cyc = 0;
   int              hs_cyc = 0;
   int              rise_lat = 0;
   logic            res_valid_prev = 1'b0;
   logic [6*W-1:0]  cur_ray = '0;
   logic            cur_cull = 1'b0;

   // per-address behaviour of the intersection unit model
   logic            hit_tbl[int];
   logic [W-1:0]    t_tbl[int];

   // unit model outputs and a spurious-return override
   logic            m_valid = 1'b0, m_hit = 1'b0;
   logic [W-1:0]    m_t = '0, m_u = '0, m_v = '0;
   logic            spur_v = 1'b0, spur_hit = 1'b0;
   logic [W-1:0]    spur_t = '0;

   assign ret_valid = spur_v | m_valid;
   assign ret_hit   = spur_v ? spur_hit : m_hit;
   assign ret_t     = spur_v ? spur_t : m_t;
   assign ret_u     = spur_v ? (spur_t ^ 32'h100) : m_u;
   assign ret_v     = spur_v ? (spur_t ^ 32'h200) : m_v;

   always @(posedge clk) cyc <= cyc + 1;

   // triangle memory: v0x carries the address so the unit model can key on it
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= {32'(mem_rd_addr), {8{32'hA5A5_0F0F}}};
   end

   // intersection unit model, latency 1
   always @(posedge clk) begin : unit_m
      int a;
      a = int'(isect_tri[9*W-1 -: W]);
      m_valid <= isect_valid;
      m_hit   <= isect_valid && hit_tbl.exists(a) && hit_tbl[a];
      m_t     <= t_tbl.exists(a) ? t_tbl[a] : 32'h0;
      m_u     <= (t_tbl.exists(a) ? t_tbl[a] : 32'h0) ^ 32'h100;
      m_v     <= (t_tbl.exists(a) ? t_tbl[a] : 32'h0) ^ 32'h200;
   end

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // monitor
   always @(negedge clk) begin
      exp_t e;
      if (req_valid && req_ready) hs_cyc = cyc;
      if (res_valid && !res_valid_prev) rise_lat = cyc - hs_cyc;
      res_valid_prev = res_valid;
      if (mem_rd_en) begin
         chk("rd_pending", 64'(addr_q.size() != 0), 64'd1);
         if (addr_q.size() != 0) chk("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
      end
      if (isect_valid) begin
         chk("isect_ray", 64'(isect_ray === cur_ray), 64'd1);
         chk("isect_cull", 64'(isect_cull), 64'(cur_cull));
      end
      if (res_valid && res_ready) begin
         chk("res_pending", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("res_hit", 64'(res_hit), 64'(e.hit));
            chk("res_t", 64'(res_t), 64'(e.t));
            chk("res_u", 64'(res_u), 64'(e.u));
            chk("res_v", 64'(res_v), 64'(e.v));
            chk("res_idx", 64'(res_idx), 64'(e.idx));
            chk("res_latency", 64'(rise_lat), 64'(e.lat));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_tri(input int a, input logic h, input logic [W-1:0] t);
      hit_tbl[a] = h;
      t_tbl[a]   = t;
   endtask

   task automatic push_exp(input logic hit, input logic [W-1:0] t, input logic [IDXW-1:0] idx,
                           input int lat);
      exp_t e;
      e.hit = hit;
      e.t   = hit ? t : '0;
      e.u   = hit ? (t ^ 32'h100) : '0;
      e.v   = hit ? (t ^ 32'h200) : '0;
      e.idx = hit ? idx : '0;
      e.lat = lat;
      sb_q.push_back(e);
   endtask

   task automatic push_addrs(input logic [IDXW-1:0] base, input int n);
      for (int i = 0; i < n; i++) addr_q.push_back(base + IDXW'(i));
   endtask

   task automatic issue(input logic [IDXW-1:0] base, input logic [CNTW-1:0] count, input logic cull);
      int g;
      g = 0;
      while (!req_ready && g < 100) begin
         tick(1);
         g++;
      end
      chk("req_ready_wait", 64'(req_ready), 64'd1);
      cur_ray   = {32'(base), 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'(count)};
      cur_cull  = cull;
      req_ray   = cur_ray;
      req_base  = base;
      req_count = count;
      req_cull  = cull;
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 300) begin
         tick(1);
         g++;
      end
      chk({nm, "_done"}, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
      chk({nm, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
      chk({nm, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'd0);
      chk({nm, "_isect_valid"}, 64'(isect_valid), 64'd0);
      chk({nm, "_res_valid"}, 64'(res_valid), 64'd0);
      chk({nm, "_res_hit_idx"}, {32'(res_hit), 16'(res_t), res_idx}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(2);
      chk_reset_outs("reset");
      rstn = 1'b1;
      tick(1);

      // three triangles at base 10, closest is the middle one
      set_tri(10, 1'b1, 32'h50);
      set_tri(11, 1'b1, 32'h20);
      set_tri(12, 1'b1, 32'h30);
      push_addrs(16'd10, 3);
      push_exp(1'b1, 32'h20, 16'd11, 6);
      issue(16'd10, 8'd3, 1'b0);
      wait_done("three_hits");

      // empty range
      push_exp(1'b0, 32'h0, 16'd0, 1);
      issue(16'd7, 8'd0, 1'b1);
      wait_done("count_zero");

      // four misses with small t that must not be taken
      for (int i = 20; i < 24; i++) set_tri(i, 1'b0, 32'h5);
      push_addrs(16'd20, 4);
      push_exp(1'b0, 32'h0, 16'd0, 7);
      issue(16'd20, 8'd4, 1'b0);
      wait_done("all_miss");

      // tie at indices 5/6 and a stalled result port with a stray return in DONE
      res_ready = 1'b0;
      set_tri(5, 1'b1, 32'h40);
      set_tri(6, 1'b1, 32'h40);
      push_addrs(16'd5, 2);
      push_exp(1'b1, 32'h40, 16'd5, 5);
      issue(16'd5, 8'd2, 1'b1);
      begin
         int g;
         g = 0;
         while (!res_valid && g < 50) begin
            tick(1);
            g++;
         end
      end
      chk("stall_valid_seen", 64'(res_valid), 64'd1);
      spur_v   = 1'b1;
      spur_hit = 1'b1;
      spur_t   = 32'h0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         spur_v = 1'b0;
         chk("stall_res_valid", 64'(res_valid), 64'd1);
         chk("stall_req_ready", 64'(req_ready), 64'd0);
         chk("stall_hold", {15'(0), res_hit, res_idx, res_t}, {15'(0), 1'b1, 16'd5, 32'h40});
      end
      res_ready = 1'b1;
      wait_done("tie_stall");

      // address wrap past 0xFFFF, hit only on the third triangle
      set_tri(32'hFFFE, 1'b0, 32'h5);
      set_tri(32'hFFFF, 1'b0, 32'h6);
      set_tri(0, 1'b1, 32'h10);
      addr_q.push_back(16'hFFFE);
      addr_q.push_back(16'hFFFF);
      addr_q.push_back(16'h0000);
      push_exp(1'b1, 32'h10, 16'h0000, 6);
      issue(16'hFFFE, 8'd3, 1'b0);
      wait_done("wrap");

      // mixed hits/misses: a low-t miss is ignored, later equal t loses
      set_tri(200, 1'b1, 32'h90);
      set_tri(201, 1'b0, 32'h10);
      set_tri(202, 1'b1, 32'h60);
      set_tri(203, 1'b1, 32'h60);
      set_tri(204, 1'b1, 32'h61);
      push_addrs(16'd200, 5);
      push_exp(1'b1, 32'h60, 16'd202, 8);
      issue(16'd200, 8'd5, 1'b1);
      wait_done("mixed");

      // reset in cycle 2 of an eight-triangle request
      for (int i = 100; i < 108; i++) set_tri(i, 1'b1, 32'h5);
      addr_q.push_back(16'd100);
      issue(16'd100, 8'd8, 1'b0);
      tick(1);
      rstn = 1'b0;
      #1;
      chk_reset_outs("midreset");
      tick(2);
      rstn = 1'b1;
      spur_v   = 1'b1;
      spur_hit = 1'b1;
      spur_t   = 32'h1;
      tick(1);
      spur_v = 1'b0;
      chk("idle_stray_ready", 64'(req_ready), 64'd1);
      chk("idle_stray_res_valid", 64'(res_valid), 64'd0);
      set_tri(40, 1'b1, 32'h70);
      addr_q.push_back(16'd40);
      push_exp(1'b1, 32'h70, 16'd40, 4);
      issue(16'd40, 8'd1, 1'b0);
      wait_done("after_reset");

      tick(3);
      chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
